// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// state encoding, memory timeout limit and datapath widths.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W  = 5;
   localparam int STALL_CNT_W = 16;

   localparam logic [3:0] MEM_TIMEOUT = 4'd15;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH2   = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: the load in EX writes a register that the
// instruction in ID actually reads. Register x0 never counts as a hazard.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] i_rs1Addr,
   input  logic [REG_ADDR_W-1:0] i_rs2Addr,
   input  logic                  i_rs1Used,
   input  logic                  i_rs2Used,
   input  logic                  i_exMemREna,
   input  logic                  i_exRegWEna,
   input  logic [REG_ADDR_W-1:0] i_exRegWAddr,
   output logic                  o_loadUse
);

   logic w_rs1Match;
   logic w_rs2Match;
   logic w_exIsLoadWrite;

   assign w_rs1Match      = i_rs1Used & (i_rs1Addr == i_exRegWAddr);
   assign w_rs2Match      = i_rs2Used & (i_rs2Addr == i_exRegWAddr);
   assign w_exIsLoadWrite = i_exMemREna & i_exRegWEna & (i_exRegWAddr != '0);

   assign o_loadUse = w_exIsLoadWrite & (w_rs1Match | w_rs2Match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: memory-wait stalls with timeout, taken-branch flushes
// (two cycles to cover the registered PC redirect) and load-use interlocks.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic                   clk_100M,
   input  logic                   rst,
   input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
   input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
   input  logic                   id_rs1_used,
   input  logic                   id_rs2_used,
   input  logic                   ex_mem_r_ena,
   input  logic                   ex_reg_w_ena,
   input  logic [REG_ADDR_W-1:0]  ex_reg_w_addr,
   input  logic                   ex_branch_taken,
   input  logic                   mem_req,
   input  logic                   dmem_ack,
   output logic                   hold_pc,
   output logic                   hold_if_id,
   output logic                   hold_id_ex,
   output logic                   hold_ex_mem,
   output logic                   flush_if_id,
   output logic                   flush_id_ex,
   output logic                   mem_err,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   state_t                 r_state;
   state_t                 w_nextState;
   logic [3:0]             r_timeout;
   logic [STALL_CNT_W-1:0] r_stallCnt;

   logic w_loadUse;
   logic w_memStall;
   logic w_stallCycle;
   logic w_runRules;
   logic w_holdAll;
   logic w_holdFront;
   logic w_flushIfId;
   logic w_flushIdEx;
   logic w_memErr;

   hazard_detect u_hazardDetect (
      .i_rs1Addr    (id_rs1_addr),
      .i_rs2Addr    (id_rs2_addr),
      .i_rs1Used    (id_rs1_used),
      .i_rs2Used    (id_rs2_used),
      .i_exMemREna  (ex_mem_r_ena),
      .i_exRegWEna  (ex_reg_w_ena),
      .i_exRegWAddr (ex_reg_w_addr),
      .o_loadUse    (w_loadUse)
   );

   assign w_memStall = mem_req & ~dmem_ack;

   always_ff @(posedge clk_100M) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The stall detection cycle counts as the first waited cycle, so a
   // missing ack gives 15 held cycles followed by the error cycle.
   always_ff @(posedge clk_100M) begin
      if (rst) begin
         r_timeout  <= '0;
         r_stallCnt <= '0;
      end else if (w_stallCycle) begin
         r_timeout <= r_timeout + 4'd1;
         if (r_stallCnt != '1) begin
            r_stallCnt <= r_stallCnt + STALL_ONE;
         end
      end else begin
         r_timeout <= '0;
      end
   end

   always_comb begin
      w_nextState  = r_state;
      w_stallCycle = 1'b0;
      w_runRules   = 1'b0;
      w_holdAll    = 1'b0;
      w_holdFront  = 1'b0;
      w_flushIfId  = 1'b0;
      w_flushIdEx  = 1'b0;
      w_memErr     = 1'b0;

      case (r_state)
         RUN, FLUSH2: begin
            if (w_memStall) begin
               w_holdAll    = 1'b1;
               w_stallCycle = 1'b1;
               w_nextState  = MEM_WAIT;
            end else if (r_state == FLUSH2) begin
               w_flushIfId = 1'b1;
               w_nextState = RUN;
            end else begin
               w_runRules = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmem_ack) begin
               w_runRules = 1'b1;
            end else if (r_timeout == MEM_TIMEOUT) begin
               w_memErr    = 1'b1;
               w_nextState = RUN;
            end else begin
               w_holdAll    = 1'b1;
               w_stallCycle = 1'b1;
            end
         end
         default: begin
            w_nextState = RUN;
         end
      endcase

      // Branch outranks load-use; both only act when memory is not stalling.
      if (w_runRules) begin
         if (ex_branch_taken) begin
            w_flushIfId = 1'b1;
            w_flushIdEx = 1'b1;
            w_nextState = FLUSH2;
         end else begin
            w_nextState = RUN;
            if (w_loadUse) begin
               w_holdFront = 1'b1;
               w_flushIdEx = 1'b1;
            end
         end
      end
   end

   assign hold_pc     = ~rst & (w_holdAll | w_holdFront);
   assign hold_if_id  = ~rst & (w_holdAll | w_holdFront);
   assign hold_id_ex  = ~rst & w_holdAll;
   assign hold_ex_mem = ~rst & w_holdAll;
   assign flush_if_id = ~rst & w_flushIfId;
   assign flush_id_ex = ~rst & w_flushIdEx;
   assign mem_err     = ~rst & w_memErr;
   assign stall_cnt   = r_stallCnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios plus random
// traffic, each cycle checked against a behavioural pipeline-control model.
module tb_pipe_ctrl;

   logic        clk_100M = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_reg_w_addr;
   logic        id_rs1_used, id_rs2_used;
   logic        ex_mem_r_ena, ex_reg_w_ena, ex_branch_taken;
   logic        mem_req, dmem_ack;
   logic        hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
   logic        flush_if_id, flush_id_ex, mem_err;
   logic [15:0] stall_cnt;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1Used;
      logic       rs2Used;
      logic       load;
      logic       wen;
      logic [4:0] waddr;
      logic       branch;
      logic       memReq;
      logic       ack;
   } stim_t;

   typedef struct packed {
      logic        holdPc;
      logic        holdIfId;
      logic        holdIdEx;
      logic        holdExMem;
      logic        flushIfId;
      logic        flushIdEx;
      logic        memErr;
      logic [15:0] stallCnt;
   } resp_t;

   resp_t expQ[$];
   int    nCompared = 0;
   int    nMismatch = 0;

   bit mWaiting      = 1'b0;
   bit mFlushPending = 1'b0;
   int mWaitCycles   = 0;
   int mStallTotal   = 0;

   always #5 clk_100M = ~clk_100M;

   pipe_ctrl dut (
      .clk_100M        (clk_100M),
      .rst             (rst),
      .id_rs1_addr     (id_rs1_addr),
      .id_rs2_addr     (id_rs2_addr),
      .id_rs1_used     (id_rs1_used),
      .id_rs2_used     (id_rs2_used),
      .ex_mem_r_ena    (ex_mem_r_ena),
      .ex_reg_w_ena    (ex_reg_w_ena),
      .ex_reg_w_addr   (ex_reg_w_addr),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .dmem_ack        (dmem_ack),
      .hold_pc         (hold_pc),
      .hold_if_id      (hold_if_id),
      .hold_id_ex      (hold_id_ex),
      .hold_ex_mem     (hold_ex_mem),
      .flush_if_id     (flush_if_id),
      .flush_id_ex     (flush_id_ex),
      .mem_err         (mem_err),
      .stall_cnt       (stall_cnt)
   );

   function automatic logic [6:0] ctrlBits();
      return {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex, mem_err};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      nCompared++;
      if (got !== want) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Drive one cycle of inputs, predict the response and advance the model.
   task automatic applyStimulus(input stim_t s);
      resp_t e;
      bit    lu;
      @(posedge clk_100M);
      #1;
      rst             = s.rst;
      id_rs1_addr     = s.rs1;
      id_rs2_addr     = s.rs2;
      id_rs1_used     = s.rs1Used;
      id_rs2_used     = s.rs2Used;
      ex_mem_r_ena    = s.load;
      ex_reg_w_ena    = s.wen;
      ex_reg_w_addr   = s.waddr;
      ex_branch_taken = s.branch;
      mem_req         = s.memReq;
      dmem_ack        = s.ack;

      e          = '0;
      e.stallCnt = 16'(mStallTotal);
      lu = s.load && s.wen && (s.waddr != 0) &&
           ((s.rs1Used && s.rs1 == s.waddr) || (s.rs2Used && s.rs2 == s.waddr));

      if (s.rst) begin
         mWaiting = 0; mFlushPending = 0; mWaitCycles = 0; mStallTotal = 0;
      end else if (!s.ack && (mWaiting ? (mWaitCycles < 15) : s.memReq)) begin
         e.holdPc = 1; e.holdIfId = 1; e.holdIdEx = 1; e.holdExMem = 1;
         mWaiting = 1;
         mFlushPending = 0;
         mWaitCycles++;
         if (mStallTotal < 65535) mStallTotal++;
      end else if (mWaiting && !s.ack) begin
         e.memErr = 1;
         mWaiting = 0;
         mWaitCycles = 0;
      end else begin
         mWaiting = 0;
         mWaitCycles = 0;
         if (mFlushPending) begin
            e.flushIfId = 1;
            mFlushPending = 0;
         end else if (s.branch) begin
            e.flushIfId = 1; e.flushIdEx = 1;
            mFlushPending = 1;
         end else if (lu) begin
            e.holdPc = 1; e.holdIfId = 1; e.flushIdEx = 1;
         end
      end
      expQ.push_back(e);
   endtask

   function automatic stim_t idleStim();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t loadUseStim(input logic [4:0] addr);
      stim_t s;
      s = '0;
      s.load = 1; s.wen = 1; s.waddr = addr; s.rs2 = addr; s.rs2Used = 1;
      s.rs1 = 5'd9; s.rs1Used = 1;
      return s;
   endfunction

   function automatic stim_t memStim(input logic ack, input logic branch);
      stim_t s;
      s = '0;
      s.memReq = 1; s.ack = ack; s.branch = branch;
      return s;
   endfunction

   function automatic stim_t resetStim();
      stim_t s;
      s = '0;
      s.rst = 1;
      return s;
   endfunction

   function automatic stim_t randomStim();
      stim_t s;
      s.rst     = ($urandom_range(0, 99) < 2);
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2     = 5'($urandom_range(0, 3));
      s.rs1Used = ($urandom_range(0, 9) < 7);
      s.rs2Used = ($urandom_range(0, 9) < 7);
      s.load    = ($urandom_range(0, 9) < 4);
      s.wen     = ($urandom_range(0, 9) < 7);
      s.waddr   = 5'($urandom_range(0, 3));
      s.branch  = ($urandom_range(0, 9) < 2);
      s.memReq  = ($urandom_range(0, 9) < 3);
      s.ack     = ($urandom_range(0, 1) == 1);
      return s;
   endfunction

   // Monitor: every negedge the DUT presents one cycle of control outputs.
   initial begin
      resp_t e;
      resp_t got;
      forever begin
         @(negedge clk_100M);
         if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            got = {ctrlBits(), stall_cnt};
            nCompared++;
            if (got !== e) begin
               nMismatch++;
               $display("[TB] FAIL cycle@%0t: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                        $time, got[22:16], got.stallCnt, e[22:16], e.stallCnt);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int nHeld;
      rst = 1'b1;
      id_rs1_addr = '0; id_rs2_addr = '0; ex_reg_w_addr = '0;
      id_rs1_used = 0; id_rs2_used = 0; ex_mem_r_ena = 0; ex_reg_w_ena = 0;
      ex_branch_taken = 0; mem_req = 0; dmem_ack = 0;
      repeat (2) @(posedge clk_100M);

      applyStimulus(resetStim());
      @(negedge clk_100M);
      checkOutput("reset_outputs", {25'd0, ctrlBits()}, 32'd0);
      checkOutput("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);

      // Load-use on rs2, then the same pattern targeting x0.
      applyStimulus(loadUseStim(5'd5));
      @(negedge clk_100M);
      checkOutput("loaduse_stall", {25'd0, ctrlBits()}, 32'b1100010);
      applyStimulus(idleStim());
      @(negedge clk_100M);
      checkOutput("loaduse_release", {25'd0, ctrlBits()}, 32'd0);
      applyStimulus(loadUseStim(5'd0));
      @(negedge clk_100M);
      checkOutput("loaduse_x0", {25'd0, ctrlBits()}, 32'd0);

      // Memory wait: three unacked cycles, then ack.
      applyStimulus(resetStim());
      nHeld = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(memStim(i == 3, 1'b0));
         @(negedge clk_100M);
         if (hold_ex_mem) nHeld++;
      end
      checkOutput("memwait_ack_holds", {25'd0, ctrlBits()}, 32'd0);
      checkOutput("memwait_hold_cycles", nHeld, 32'd3);
      applyStimulus(idleStim());
      @(negedge clk_100M);
      checkOutput("memwait_stall_cnt", {16'd0, stall_cnt}, 32'd3);

      // Timeout: ack never comes.
      applyStimulus(resetStim());
      nHeld = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(memStim(1'b0, 1'b0));
         @(negedge clk_100M);
         if (hold_pc) nHeld++;
      end
      checkOutput("timeout_hold_cycles", nHeld, 32'd15);
      checkOutput("timeout_err_cycle", {25'd0, ctrlBits()}, 32'b0000001);
      applyStimulus(idleStim());
      @(negedge clk_100M);
      checkOutput("timeout_back_to_run", {25'd0, ctrlBits()}, 32'd0);

      // Branch with a simultaneous load-use match, then the FLUSH2 cycle.
      applyStimulus(resetStim());
      begin
         stim_t s;
         s = loadUseStim(5'd7);
         s.branch = 1;
         applyStimulus(s);
         @(negedge clk_100M);
         checkOutput("branch_cycle_n", {25'd0, ctrlBits()}, 32'b0000110);
         applyStimulus(loadUseStim(5'd7));
         @(negedge clk_100M);
         checkOutput("branch_cycle_n1", {25'd0, ctrlBits()}, 32'b0000100);
      end

      // Ack together with a taken branch in MEM_WAIT.
      applyStimulus(resetStim());
      applyStimulus(memStim(1'b0, 1'b0));
      applyStimulus(memStim(1'b0, 1'b1));
      applyStimulus(memStim(1'b1, 1'b1));
      @(negedge clk_100M);
      checkOutput("ack_branch_flush", {25'd0, ctrlBits()}, 32'b0000110);
      applyStimulus(idleStim());
      @(negedge clk_100M);
      checkOutput("ack_branch_flush2", {25'd0, ctrlBits()}, 32'b0000100);

      // Reset during the second MEM_WAIT cycle.
      applyStimulus(resetStim());
      applyStimulus(memStim(1'b0, 1'b0));
      applyStimulus(memStim(1'b0, 1'b0));
      begin
         stim_t s;
         s = memStim(1'b0, 1'b0);
         s.rst = 1;
         applyStimulus(s);
      end
      @(negedge clk_100M);
      checkOutput("midwait_reset_outs", {25'd0, ctrlBits()}, 32'd0);
      applyStimulus(idleStim());
      @(negedge clk_100M);
      checkOutput("midwait_after_outs", {25'd0, ctrlBits()}, 32'd0);
      checkOutput("midwait_stall_cnt", {16'd0, stall_cnt}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         applyStimulus(randomStim());
      end

      repeat (3) @(negedge clk_100M);
      checkOutput("queue_drained", expQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The module SHALL have a single clock domain and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk_100M  in  1  system clock; all state on the rising edge.
- rst  in  1  synchronous active-high reset.
- id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1 each  source actually read.
- ex_mem_r_ena  in  1  instruction in EX is a load.
- ex_reg_w_ena  in  1  instruction in EX writes a register.
- ex_reg_w_addr  in  5  its destination register.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  EX/MEM register holds a memory access (read or write enable).
- dmem_ack  in  1  data memory completes the access this cycle.
- hold_pc, hold_if_id, hold_id_ex, hold_ex_mem  out  1 each  freeze the PC and the pipeline registers.
- flush_if_id, flush_id_ex  out  1 each  load a bubble into the pipeline register.
- mem_err  out  1  one-cycle pulse on memory timeout.
- stall_cnt  out  16  saturating count of memory-wait cycles.

Function
REQ-003 The FSM SHALL have three states: RUN, MEM_WAIT and FLUSH2.
REQ-004 In RUN, a memory stall SHALL be detected when mem_req=1 and dmem_ack=0.
REQ-005 On a memory stall, all four hold outputs SHALL assert in the same cycle (combinational), all flushes SHALL stay 0, and next state SHALL be MEM_WAIT.
REQ-006 In MEM_WAIT, while dmem_ack=0, all four holds SHALL stay 1 and the flushes SHALL stay 0.
REQ-007 In MEM_WAIT, the 4-bit timeout counter SHALL increment every cycle, and stall_cnt SHALL increment, saturating at 0xFFFF.
REQ-008 In MEM_WAIT, when dmem_ack=1, all holds SHALL deassert that cycle and the RUN rules (REQ-011..013) SHALL apply combinationally in that cycle.
REQ-009 On the dmem_ack=1 transition, next state SHALL be FLUSH2 if ex_branch_taken=1, else RUN, and the timeout counter SHALL clear.
REQ-010 If the timeout counter equals 15 and dmem_ack=0, the controller SHALL pulse mem_err for that cycle, deassert the holds, clear the counter and return to RUN.
REQ-011 Branch flush: in RUN with no memory stall and ex_branch_taken=1, flush_if_id and flush_id_ex SHALL assert in the same cycle and next state SHALL be FLUSH2.
REQ-012 In FLUSH2, flush_if_id SHALL assert for exactly one cycle to cover the registered PC redirect, load-use detection SHALL be suppressed, and next state SHALL be RUN. A memory stall in FLUSH2 has priority per REQ-005.
REQ-013 Load-use: in RUN with no memory stall and no branch, if ex_mem_r_ena & ex_reg_w_ena & ex_reg_w_addr!=0 matches a used rs, then hold_pc=1, hold_if_id=1 and flush_id_ex=1 for exactly one cycle.
REQ-014 Priority SHALL be: memory stall > branch flush > load-use.
REQ-015 Register x0 SHALL never cause a load-use stall.
REQ-016 hold_* and flush_* SHALL never both be asserted for the same pipeline register.
REQ-017 ex_branch_taken SHALL be ignored while the holds are asserted in MEM_WAIT.

Reset
REQ-018 While rst=1, at each clock edge the state SHALL become RUN and the timeout counter and stall_cnt SHALL become 0.
REQ-019 While rst=1, all hold, flush and mem_err outputs SHALL be forced to 0.
REQ-020 A reset asserted mid-MEM_WAIT or mid-FLUSH2 SHALL abandon the sequence with no mem_err pulse.

Structure
REQ-021 A shared package SHALL hold the state encoding (RUN=2'd0, MEM_WAIT=2'd1, FLUSH2=2'd2), MEM_TIMEOUT=4'd15, the register-address width 5 and the stall_cnt width 16.
REQ-022 The load-use comparison SHALL be a combinational sub-module hazard_detect; the FSM, counters and output priority logic SHALL reside in pipe_ctrl.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Load-use: ex_mem_r_ena=1, ex_reg_w_ena=1, ex_reg_w_addr=5, id_rs2_addr=5, id_rs2_used=1 -> exactly one cycle of hold_pc=hold_if_id=flush_id_ex=1; the same stimulus with addr=0 -> no stall.
- Memory wait: mem_req=1 and dmem_ack low for 3 cycles then high -> holds high for 3 cycles and low in the ack cycle; stall_cnt=3.
- Timeout: mem_req=1 and dmem_ack never high -> holds high for 15 cycles, mem_err pulses on the 16th cycle, state returns to RUN.
- Branch: ex_branch_taken=1 in RUN -> cycle N flush_if_id=flush_id_ex=1, cycle N+1 flush_if_id only; a simultaneous load-use match yields no hold.
- Ack with branch: dmem_ack=1 together with ex_branch_taken=1 in MEM_WAIT -> both flushes in that cycle, FLUSH2 on the next cycle.
- Reset mid-wait: rst=1 at MEM_WAIT cycle 2 -> all outputs 0 the next cycle, stall_cnt=0, no mem_err.
